fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage feeding the decode control block (`lut`) of the miniMips core. It owns the program counter and drives a synchronous instruction ROM with one-cycle read latency. A 2-entry prefetch buffer with a valid/ready handshake sits between the ROM and decode. It also applies taken-branch redirects (PC-relative, same arithmetic as the core's PC adder) and detects the halt instruction, raising `done`.

## Interface
- `PC_W`, 8, program counter / ROM address width
- `INSTR_W`, 9, instruction width
- `HALT_INSTR`, 9'b101100100, encoding that halts fetch
- `clk`  in  1  single clock, all state updates on rising edge
- `start`  in  1  synchronous, active-high reset; also the program-start pulse
- `imem_en`  out  1  ROM read strobe; a read is issued when high
- `imem_addr`  out  PC_W  ROM address for the issued read
- `imem_data`  in  INSTR_W  ROM data, valid the cycle after the read is issued
- `instr`  out  INSTR_W  instruction at buffer head
- `instr_pc`  out  PC_W  address of `instr`
- `instr_valid`  out  1  buffer head holds a live instruction
- `instr_ready`  in  1  decode accepts head this cycle
- `redirect`  in  1  taken branch for the instruction accepted this cycle
- `redirect_offset`  in  PC_W  branch offset (two's-complement, from register file)
- `done`  out  1  halt instruction accepted; core stopped

## Operation
- Internal state: `fetch_pc`, in-flight flag `ifl` plus its PC, 2-entry FIFO of {instr, pc}, occupancy `cnt` (0..2), state RUN/HALTED.
- Reset (`start`=1): `fetch_pc`=0, `ifl`=0, `cnt`=0, state=RUN. Outputs: `imem_en`=0, `imem_addr`=0, `instr`=0, `instr_pc`=0, `instr_valid`=0, `done`=0. A ROM response arriving in the cycle after reset is discarded.
- Accept: `pop` = `instr_valid` & `instr_ready`.
- Issue (RUN, no redirect, no halt accept this cycle): `imem_en`=1 iff `cnt` + `ifl` − `pop` < 2. `imem_addr`=`fetch_pc`, then `fetch_pc` increments mod 2^PC_W (255 -> 0), and `ifl` is set with that PC.
- Return: when `ifl` is set, `imem_data` and the stored PC are pushed into the FIFO at the clock edge. They are never dropped; the credit rule guarantees space. Push and pop may occur in the same cycle.
- `instr`/`instr_pc`/`instr_valid` are driven from the FIFO head registers, not a combinational path from `imem_data`.
- Redirect: sampled only when `pop`=1; ignored otherwise.
  - `fetch_pc` := `instr_pc` + `redirect_offset` mod 2^PC_W.
  - FIFO flushed (`cnt`=0), `ifl` cleared; the next cycle's ROM data is discarded.
  - No read is issued in the redirect cycle.
- Halt: `pop`=1 with `instr`==`HALT_INSTR` -> state HALTED.
  - Halt wins over a simultaneous `redirect`.
  - FIFO flushed, `ifl` cleared, `done`=1 from next cycle.
  - `instr_valid`=0 and `imem_en`=0 while HALTED.
  - HALTED exits only via `start`.
- With `instr_ready`=0 the head is held stable: `instr`, `instr_pc`, `instr_valid` do not change. Fetch stops once `cnt` + `ifl` = 2.

## Timing
- Reset to first instruction: `start` high in cycle 0. Cycle 1: `imem_en`=1, addr 0. Cycle 2: data returns. Cycle 3: `instr_valid`=1, `instr_pc`=0.
- Steady state with `instr_ready` held high: one instruction per cycle, consecutive PCs.
- Redirect accepted in cycle N: target issued in N+1, `instr_valid` with `instr_pc`=target in N+3. `instr_valid`=0 in N+1 and N+2.
- Halt accepted in cycle N: `done`=1 from N+1. `instr_valid`=0 from N+1.
- `start` mid-operation overrides everything in that cycle, including an accept, redirect or halt.

## Test plan
- Reset, ROM[i]=i, `instr_ready`=1 -> `instr_pc` 0,1,2,3… on consecutive cycles from cycle 3; `imem_en` asserted every cycle from cycle 1.
- Backpressure: `instr_ready`=0 for 5 cycles at pc 4 -> head holds pc 4, `imem_en` drops after two outstanding reads. Release -> pc 4,5,6 with no gap or duplicate.
- Redirect at `instr_pc`=0x10, offset 0xF8 (−8) -> next valid `instr_pc`=0x08 exactly 3 cycles later; pcs 0x11/0x12 never presented.
- Wrap: redirect at pc 0xFE, offset 0x01 -> 0xFF then 0x00 presented. Redirect at pc 0x80, offset 0x90 -> 0x10.
- Halt: `HALT_INSTR` at ROM[3] with `redirect`=1 on accept -> `done`=1 next cycle, `instr_valid`=0, `imem_en`=0; redirect ignored. Stays halted 20 cycles.
- `start` pulse while HALTED and while a read is in flight -> `done`=0, stale data discarded, fetch restarts at pc 0 with first valid 3 cycles after the pulse.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction ROM,
// buffers returns in a 2-entry FIFO with valid/ready handoff, applies redirects and halts.
module fetch_unit #(
   parameter int                 PC_W       = 8,
   parameter int                 INSTR_W    = 9,
   parameter logic [INSTR_W-1:0] HALT_INSTR = 9'b101100100
) (
   input  logic               i_clk,
   input  logic               i_start,
   output logic               o_imem_en,
   output logic [PC_W-1:0]    o_imem_addr,
   input  logic [INSTR_W-1:0] i_imem_data,
   output logic [INSTR_W-1:0] o_instr,
   output logic [PC_W-1:0]    o_instr_pc,
   output logic               o_instr_valid,
   input  logic               i_instr_ready,
   input  logic               i_redirect,
   input  logic [PC_W-1:0]    i_redirect_offset,
   output logic               o_done
);

   typedef enum logic {
      S_RUN,
      S_HALTED
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [PC_W-1:0]    r_fetch_pc;
   logic               r_ifl;
   logic [PC_W-1:0]    r_ifl_pc;
   logic [INSTR_W-1:0] r_fifo_instr [2];
   logic [PC_W-1:0]    r_fifo_pc    [2];
   logic [1:0]         r_cnt;

   logic               w_pop;
   logic               w_push;
   logic               w_halt_take;
   logic               w_redir_take;
   logic               w_flush;
   logic               w_issue;
   logic [2:0]         w_used;
   logic [2:0]         w_limit;

   assign o_instr       = r_fifo_instr[0];
   assign o_instr_pc    = r_fifo_pc[0];
   assign o_instr_valid = (r_state == S_RUN) && (r_cnt != 2'd0);
   assign o_done        = (r_state == S_HALTED);
   assign o_imem_addr   = r_fetch_pc;
   assign o_imem_en     = w_issue;

   // A read is in flight exactly one cycle, so the in-flight flag doubles as the push strobe.
   assign w_push = r_ifl;

   always_comb begin
      w_state_nxt  = r_state;
      w_pop        = o_instr_valid && i_instr_ready;
      w_halt_take  = w_pop && (r_fifo_instr[0] == HALT_INSTR);
      w_redir_take = w_pop && i_redirect && !w_halt_take;
      w_flush      = w_halt_take || w_redir_take;
      w_used       = {1'b0, r_cnt} + {2'b00, r_ifl};
      w_limit      = 3'd2 + {2'b00, w_pop};
      // Credit check: buffered + in-flight, less the entry leaving now, must stay below 2.
      w_issue      = (r_state == S_RUN) && !w_flush && !i_start && (w_used < w_limit);
      if (r_state == S_RUN && w_halt_take) begin
         w_state_nxt = S_HALTED;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_start) begin
         r_state    <= S_RUN;
         r_fetch_pc <= '0;
         r_ifl      <= 1'b0;
         r_ifl_pc   <= '0;
         r_cnt      <= 2'd0;
         // NOTE: the FIFO entries are reset because the head entry drives o_instr/o_instr_pc,
         // which must read zero straight out of reset.
         for (int i = 0; i < 2; i++) begin
            r_fifo_instr[i] <= '0;
            r_fifo_pc[i]    <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         r_ifl   <= w_issue;
         if (w_issue) begin
            r_ifl_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + PC_W'(1);
         end else if (w_redir_take) begin
            r_fetch_pc <= o_instr_pc + i_redirect_offset;
         end

         if (w_flush) begin
            r_cnt <= 2'd0;
         end else begin
            case ({w_push, w_pop})
               2'b10: begin
                  if (r_cnt == 2'd0) begin
                     r_fifo_instr[0] <= i_imem_data;
                     r_fifo_pc[0]    <= r_ifl_pc;
                  end else begin
                     r_fifo_instr[1] <= i_imem_data;
                     r_fifo_pc[1]    <= r_ifl_pc;
                  end
                  r_cnt <= r_cnt + 2'd1;
               end
               2'b01: begin
                  r_fifo_instr[0] <= r_fifo_instr[1];
                  r_fifo_pc[0]    <= r_fifo_pc[1];
                  r_cnt           <= r_cnt - 2'd1;
               end
               2'b11: begin
                  if (r_cnt == 2'd1) begin
                     r_fifo_instr[0] <= i_imem_data;
                     r_fifo_pc[0]    <= r_ifl_pc;
                  end else begin
                     r_fifo_instr[0] <= r_fifo_instr[1];
                     r_fifo_pc[0]    <= r_fifo_pc[1];
                     r_fifo_instr[1] <= i_imem_data;
                     r_fifo_pc[1]    <= r_ifl_pc;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM model with ROM[i]=i, hand-computed expectations per cycle.
module tb_fetch_unit;

   localparam logic [8:0] HALT = 9'b101100100;

   logic       clk = 1'b0;
   logic       start;
   logic       imem_en;
   logic [7:0] imem_addr;
   logic [8:0] imem_data;
   logic [8:0] instr;
   logic [7:0] instr_pc;
   logic       instr_valid;
   logic       instr_ready;
   logic       redirect;
   logic [7:0] redirect_offset;
   logic       done;

   logic [8:0] rom [256];

   int vectors    = 0;
   int miscompares = 0;

   fetch_unit dut (
      .i_clk             (clk),
      .i_start           (start),
      .o_imem_en         (imem_en),
      .o_imem_addr       (imem_addr),
      .i_imem_data       (imem_data),
      .o_instr           (instr),
      .o_instr_pc        (instr_pc),
      .o_instr_valid     (instr_valid),
      .i_instr_ready     (instr_ready),
      .i_redirect        (redirect),
      .i_redirect_offset (redirect_offset),
      .o_done            (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (imem_en) imem_data <= rom[imem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pc(input logic [7:0] pc);
      int n = 0;
      while (!(instr_valid && instr_pc == pc) && n < 400) begin
         tick();
         n++;
      end
      check("wait_pc", 32'({instr_valid, instr_pc}), 32'({1'b1, pc}));
   endtask

   // Redirect taken on the current head; target must appear exactly three cycles later.
   task automatic redirect_to(input logic [7:0] off, input logic [7:0] tgt, input string tag);
      check({tag, "_head"}, 32'(instr_valid), 1);
      redirect = 1'b1;
      redirect_offset = off;
      #1;
      check({tag, "_no_issue"}, 32'(imem_en), 0);
      tick();
      redirect = 1'b0;
      #1;
      check({tag, "_n1"}, 32'({instr_valid, imem_en, imem_addr}), 32'({2'b01, tgt}));
      tick();
      check({tag, "_n2_valid"}, 32'(instr_valid), 0);
      tick();
      check({tag, "_n3"}, 32'({instr_valid, instr_pc, instr}), 32'({1'b1, tgt, 1'b0, tgt}));
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 9'(i);
      start = 1'b1;
      instr_ready = 1'b1;
      redirect = 1'b0;
      redirect_offset = 8'h00;

      // Reset state
      tick();
      tick();
      check("rst_en",    32'(imem_en), 0);
      check("rst_addr",  32'(imem_addr), 0);
      check("rst_instr", 32'(instr), 0);
      check("rst_pc",    32'(instr_pc), 0);
      check("rst_valid", 32'(instr_valid), 0);
      check("rst_done",  32'(done), 0);

      // Cycle 1..3: first read, return, first valid
      start = 1'b0;
      #1;
      check("c1_issue", 32'({imem_en, imem_addr, instr_valid}), 32'({1'b1, 8'h00, 1'b0}));
      tick();
      check("c2_issue", 32'({imem_en, imem_addr, instr_valid}), 32'({1'b1, 8'h01, 1'b0}));
      tick();
      check("c3_first", 32'({instr_valid, instr_pc, instr}), 32'({1'b1, 8'h00, 9'h000}));
      for (int p = 1; p <= 4; p++) begin
         tick();
         check("stream", 32'({instr_valid, instr_pc, imem_en}), 32'({1'b1, 8'(p), 1'b1}));
      end

      // Backpressure at pc 4 for five cycles
      instr_ready = 1'b0;
      #1;
      check("bp_en_drop", 32'(imem_en), 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("bp_hold", 32'({instr_valid, instr_pc, instr, imem_en}), 32'({1'b1, 8'h04, 9'h004, 1'b0}));
      end
      instr_ready = 1'b1;
      #1;
      check("bp_release", 32'({instr_pc, imem_en, imem_addr}), 32'({8'h04, 1'b1, 8'h06}));
      tick();
      check("bp_pc5", 32'({instr_valid, instr_pc}), 32'({1'b1, 8'h05}));
      tick();
      check("bp_pc6", 32'({instr_valid, instr_pc}), 32'({1'b1, 8'h06}));

      // Redirects, including PC wraparound
      wait_pc(8'h10);
      redirect_to(8'hF8, 8'h08, "redir_back");
      redirect_to(8'hF6, 8'hFE, "redir_fe");
      redirect_to(8'h01, 8'hFF, "redir_ff");
      tick();
      check("wrap_00", 32'({instr_valid, instr_pc, instr}), 32'({1'b1, 8'h00, 9'h000}));
      redirect_to(8'h80, 8'h80, "redir_80");
      redirect_to(8'h90, 8'h10, "redir_wrap10");

      // Halt at ROM[3] with a simultaneous redirect
      rom[3] = HALT;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("h_pc0", 32'({instr_valid, instr_pc}), 32'({1'b1, 8'h00}));
      tick();
      tick();
      tick();
      check("h_head", 32'({instr_valid, instr_pc, instr}), 32'({1'b1, 8'h03, HALT}));
      redirect = 1'b1;
      redirect_offset = 8'h20;
      #1;
      check("h_no_issue", 32'(imem_en), 0);
      tick();
      redirect = 1'b0;
      check("h_done", 32'({done, instr_valid, imem_en}), 32'(3'b100));
      for (int k = 0; k < 20; k++) begin
         tick();
         check("h_stay", 32'({done, instr_valid, imem_en}), 32'(3'b100));
      end

      // Restart from HALTED
      rom[3] = 9'h003;
      start = 1'b1;
      tick();
      start = 1'b0;
      #1;
      check("rs_c1", 32'({done, instr_valid, imem_en, imem_addr}), 32'({3'b001, 8'h00}));
      tick();
      check("rs_c2", 32'(instr_valid), 0);
      tick();
      check("rs_c3", 32'({instr_valid, instr_pc}), 32'({1'b1, 8'h00}));
      tick();
      check("rs_pc1", 32'({instr_valid, instr_pc}), 32'({1'b1, 8'h01}));

      // Restart with a read in flight: stale return must be discarded
      start = 1'b1;
      #1;
      check("if_start_en", 32'(imem_en), 0);
      tick();
      start = 1'b0;
      #1;
      check("if_c1", 32'({done, instr_valid, imem_en, imem_addr}), 32'({3'b001, 8'h00}));
      tick();
      check("if_c2", 32'(instr_valid), 0);
      tick();
      check("if_c3", 32'({instr_valid, instr_pc, instr}), 32'({1'b1, 8'h00, 9'h000}));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
